// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store port: access-size codes,
// responder states, and lane/legality helpers used by LSU decode and dmem_responder.
package dmem_pkg;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   // Byte-lane enables for a store of the given size at the given word offset.
   function automatic logic [3:0] lane_enables(input logic [2:0] f3, input logic [1:0] lane);
      case (f3[1:0])
         2'b00:   return 4'b0001 << lane;
         2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
      if (is_store)
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      else
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load-result formatter: selects the addressed byte/half of a RAM word and
// sign- or zero-extends it to 32 bits according to the access code.
module dmem_load_ext
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[8*lane +: 8];
      half_sel = lane[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   result = {24'h0, byte_sel};
         F3_H:    result = {{16{half_sel[15]}}, half_sel};
         F3_HU:   result = {16'h0, half_sel};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the datapath load/store port: latches one request, waits
// WAIT_CYCLES, then answers for one cycle from/into the internal word RAM.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        MemReq,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        MemReady,
   output logic        MemErr
);

   localparam int AW = $clog2(DEPTH_WORDS);

   state_e      state, state_nxt;
   logic [3:0]  wait_cnt, wait_cnt_nxt;

   logic [31:0] adr_q;
   logic [31:0] wdata_q;
   logic [2:0]  f3_q;
   logic        we_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0] offset;
   logic [AW-1:0] idx;
   logic        misaligned, out_of_range, illegal, err;
   logic [3:0]  lanes;
   logic [31:0] wdata_rep;
   logic [31:0] rd_word, ld_result;
   logic        commit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Request copies are only captured on acceptance; later input changes are ignored.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && MemReq) begin
         adr_q   <= DataAdr;
         wdata_q <= WriteData;
         f3_q    <= Funct3;
         we_q    <= MemWrite;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         S_IDLE: begin
            if (MemReq) begin
               if (WAIT_CYCLES == 0) begin
                  state_nxt = S_RESP;
               end else begin
                  state_nxt    = S_WAIT;
                  wait_cnt_nxt = 4'd1;
               end
            end
         end
         S_WAIT: begin
            if (wait_cnt == 4'(WAIT_CYCLES)) begin
               state_nxt    = S_RESP;
               wait_cnt_nxt = 4'd0;
            end else begin
               wait_cnt_nxt = wait_cnt + 4'd1;
            end
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Offset wraps for addresses below BASE_ADDR, so they land in the out-of-range check.
   always_comb begin
      offset       = adr_q - BASE_ADDR;
      idx          = offset[AW+1:2];
      misaligned   = ((f3_q[1:0] == 2'b01) && adr_q[0]) ||
                     ((f3_q[1:0] == 2'b10) && (adr_q[1:0] != 2'b00));
      out_of_range = (offset >> 2) >= 32'(DEPTH_WORDS);
      illegal      = !f3_legal(f3_q, we_q);
      err          = misaligned || out_of_range || illegal;
      lanes        = lane_enables(f3_q, adr_q[1:0]);
      case (f3_q[1:0])
         2'b00:   wdata_rep = {4{wdata_q[7:0]}};
         2'b01:   wdata_rep = {2{wdata_q[15:0]}};
         default: wdata_rep = wdata_q;
      endcase
      rd_word      = mem[idx];
      commit       = (state == S_RESP) && we_q && !err;
   end

   always_ff @(posedge clk) begin
      if (commit) begin
         for (int l = 0; l < 4; l++) begin
            if (lanes[l]) mem[idx][8*l +: 8] <= wdata_rep[8*l +: 8];
         end
      end
   end

   dmem_load_ext u_load_ext (
      .word   (rd_word),
      .lane   (adr_q[1:0]),
      .funct3 (f3_q),
      .result (ld_result)
   );

   always_comb begin
      MemReady = 1'b0;
      MemErr   = 1'b0;
      ReadData = 32'h0;
      if (state == S_RESP) begin
         MemReady = 1'b1;
         MemErr   = err;
         if (!we_q && !err) ReadData = ld_result;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state, one with none.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;

   logic        MemReq = 1'b0, MemWrite = 1'b0;
   logic [2:0]  Funct3 = 3'b0;
   logic [31:0] DataAdr = 32'h0, WriteData = 32'h0;
   logic [31:0] ReadData;
   logic        MemReady, MemErr;

   logic        req0 = 1'b0, we0 = 1'b0;
   logic [2:0]  f30 = 3'b0;
   logic [31:0] adr0 = 32'h0, wd0 = 32'h0;
   logic [31:0] rd0;
   logic        rdy0, err0;

   int checks = 0;
   int failures = 0;

   logic [31:0] rd;
   logic        er;
   int          lat;
   int          pulses;
   logic        seen_rdy;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .reset_n(reset_n), .MemReq(MemReq), .MemWrite(MemWrite), .Funct3(Funct3),
      .DataAdr(DataAdr), .WriteData(WriteData), .ReadData(ReadData), .MemReady(MemReady),
      .MemErr(MemErr)
   );

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
      .clk(clk), .reset_n(reset_n), .MemReq(req0), .MemWrite(we0), .Funct3(f30),
      .DataAdr(adr0), .WriteData(wd0), .ReadData(rd0), .MemReady(rdy0), .MemErr(err0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request on the WAIT_CYCLES=1 instance; latency counts edges from acceptance.
   task automatic xact(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic scramble,
                       output logic [31:0] r, output logic e, output int l);
      MemReq = 1'b1; MemWrite = w; Funct3 = f3; DataAdr = a; WriteData = d;
      l = 0;
      do begin
         @(posedge clk); #1;
         l++;
         if (scramble && l == 1) begin
            DataAdr = 32'h0000_0020; WriteData = 32'h0BAD_0BAD; Funct3 = 3'b111; MemWrite = 1'b1;
         end
      end while (!MemReady && l < 20);
      r = ReadData; e = MemErr;
      MemReq = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'b0, MemReady}, 32'd0);
      chk("rst_err", {31'b0, MemErr}, 32'd0);
      chk("rst_rdata", ReadData, 32'h0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Word store then load, with latency
      xact(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0, rd, er, lat);
      chk("sw_lat", lat, 2);
      chk("sw_err", {31'b0, er}, 32'd0);
      chk("sw_rdata", rd, 32'h0);
      xact(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, rd, er, lat);
      chk("lw_lat", lat, 2);
      chk("lw_err", {31'b0, er}, 32'd0);
      chk("lw_rdata_latched", rd, 32'hDEAD_BEEF);

      // Byte store, signed/unsigned byte loads
      xact(1'b1, 3'b000, 32'h13, 32'h0000_0080, 1'b0, rd, er, lat);
      xact(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, rd, er, lat);
      chk("lb_13", rd, 32'hFFFF_FF80);
      xact(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, rd, er, lat);
      chk("lbu_13", rd, 32'h0000_0080);
      xact(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, er, lat);
      chk("lw_after_sb", rd, 32'h80AD_BEEF);
      xact(1'b0, 3'b000, 32'h11, 32'h0, 1'b0, rd, er, lat);
      chk("lb_11", rd, 32'hFFFF_FFBE);

      // Half store, misaligned accesses
      xact(1'b1, 3'b010, 32'h20, 32'h0000_0000, 1'b0, rd, er, lat);
      xact(1'b1, 3'b001, 32'h22, 32'hFFFF_1234, 1'b0, rd, er, lat);
      xact(1'b0, 3'b101, 32'h22, 32'h0, 1'b0, rd, er, lat);
      chk("lhu_22", rd, 32'h0000_1234);
      xact(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, rd, er, lat);
      chk("lw_20_lanes", rd, 32'h1234_0000);
      xact(1'b1, 3'b001, 32'h20, 32'h0000_8001, 1'b0, rd, er, lat);
      xact(1'b0, 3'b001, 32'h20, 32'h0, 1'b0, rd, er, lat);
      chk("lh_20_sext", rd, 32'hFFFF_8001);
      xact(1'b0, 3'b001, 32'h21, 32'h0, 1'b0, rd, er, lat);
      chk("lh_21_err", {31'b0, er}, 32'd1);
      chk("lh_21_rdata", rd, 32'h0);
      xact(1'b1, 3'b010, 32'h11, 32'hCAFE_F00D, 1'b0, rd, er, lat);
      chk("sw_11_err", {31'b0, er}, 32'd1);
      xact(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, er, lat);
      chk("lw_10_unchanged", rd, 32'h80AD_BEEF);

      // Range and illegal-code errors
      xact(1'b0, 3'b010, 32'h1000, 32'h0, 1'b0, rd, er, lat);
      chk("lw_oor_err", {31'b0, er}, 32'd1);
      chk("lw_oor_rdata", rd, 32'h0);
      xact(1'b1, 3'b010, 32'hFFC, 32'hA5A5_5A5A, 1'b0, rd, er, lat);
      chk("sw_top_err", {31'b0, er}, 32'd0);
      xact(1'b0, 3'b010, 32'hFFC, 32'h0, 1'b0, rd, er, lat);
      chk("lw_top", rd, 32'hA5A5_5A5A);
      xact(1'b0, 3'b011, 32'h10, 32'h0, 1'b0, rd, er, lat);
      chk("ld_f3_011_err", {31'b0, er}, 32'd1);
      xact(1'b1, 3'b100, 32'h10, 32'h0000_0077, 1'b0, rd, er, lat);
      chk("st_f3_100_err", {31'b0, er}, 32'd1);
      xact(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, er, lat);
      chk("lw_10_no_write", rd, 32'h80AD_BEEF);

      // Reset during WAIT and during RESP aborts the store
      xact(1'b1, 3'b010, 32'h40, 32'h1111_2222, 1'b0, rd, er, lat);
      MemReq = 1'b1; MemWrite = 1'b1; Funct3 = 3'b010; DataAdr = 32'h40; WriteData = 32'h55;
      @(posedge clk); #1;
      MemReq = 1'b0;
      reset_n = 1'b0;
      seen_rdy = 1'b0;
      repeat (3) begin
         #1 seen_rdy = seen_rdy | MemReady;
         @(posedge clk);
      end
      #1;
      chk("rst_wait_no_ready", {31'b0, seen_rdy}, 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      xact(1'b0, 3'b010, 32'h40, 32'h0, 1'b0, rd, er, lat);
      chk("lw_40_after_wait_rst", rd, 32'h1111_2222);
      MemReq = 1'b1; MemWrite = 1'b1; Funct3 = 3'b010; DataAdr = 32'h40; WriteData = 32'h66;
      @(posedge clk); #1;
      MemReq = 1'b0;
      @(posedge clk); #1;
      chk("resp_reached", {31'b0, MemReady}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rst_resp_ready_low", {31'b0, MemReady}, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      xact(1'b0, 3'b010, 32'h40, 32'h0, 1'b0, rd, er, lat);
      chk("lw_40_after_resp_rst", rd, 32'h1111_2222);

      // Zero wait states: store, then loads with request held high
      req0 = 1'b1; we0 = 1'b1; f30 = 3'b010; adr0 = 32'h8; wd0 = 32'h0BAD_CAFE;
      @(posedge clk); #1;
      chk("w0_sw_ready", {31'b0, rdy0}, 32'd1);
      req0 = 1'b0;
      @(posedge clk); #1;
      req0 = 1'b1; we0 = 1'b0;
      pulses = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         chk($sformatf("w0_ready_%0d", k), {31'b0, rdy0}, {31'b0, k[0]});
         if (rdy0) begin
            pulses++;
            chk($sformatf("w0_rdata_%0d", k), rd0, 32'h0BAD_CAFE);
         end
      end
      req0 = 1'b0;
      chk("w0_pulses", pulses, 4);
      @(posedge clk); #1;
      chk("w0_idle_ready", {31'b0, rdy0}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
